// File: rtl/retire_window.sv
`default_nettype none
// retire_window: in-order multi-wide commit stage with registered store port and precise-fault flush FSM.
// Define RETIRE_PERF_EN to add saturating perf_retired_o / perf_stall_o counters.
module retire_window #(
  parameter int RETIRE_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int REG_BITS     = 5,
  parameter int TAG_BITS     = 6
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             retire_stall_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_valid_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_ready_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_exc_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_store_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_regwr_i,
  input  logic [RETIRE_WIDTH*TAG_BITS-1:0] rob_tag_i,
  input  logic [RETIRE_WIDTH*REG_BITS-1:0] rob_rd_i,
  input  logic [RETIRE_WIDTH*XLEN-1:0]     rob_value_i,
  input  logic                             lsq_valid_i,
  input  logic [TAG_BITS-1:0]              lsq_tag_i,
  input  logic [XLEN-1:0]                  lsq_addr_i,
  input  logic [XLEN-1:0]                  lsq_data_i,
  input  logic [1:0]                       lsq_size_i,
  output logic [RETIRE_WIDTH-1:0]          regwr_o,
  output logic [RETIRE_WIDTH*REG_BITS-1:0] rd_o,
  output logic [RETIRE_WIDTH*XLEN-1:0]     value_o,
  output logic [RETIRE_WIDTH-1:0]          victim_o,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0] rob_decrement_o,
  output logic                             lsq_decrement_o,
  output logic                             st_valid_o,
  input  logic                             st_ready_i,
  output logic [XLEN-1:0]                  st_addr_o,
  output logic [XLEN-1:0]                  st_data_o,
  output logic [7:0]                       st_mask_o,
  output logic                             flush_o,
  output logic [TAG_BITS-1:0]              exc_tag_o
`ifdef RETIRE_PERF_EN
  ,
  output logic [63:0]                      perf_retired_o,
  output logic [31:0]                      perf_stall_o
`endif
);

  localparam int DEC_BITS = $clog2(RETIRE_WIDTH+1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;

  state_e                  state_q;
  logic                    flush_q;
  logic [TAG_BITS-1:0]     exc_tag_q;
  logic                    st_valid_q, st_valid_d;
  logic [XLEN-1:0]         st_addr_q, st_data_q;
  logic [7:0]              st_mask_q, st_mask_d;
  logic [15:0]             mask_base, mask_wide;
  logic [RETIRE_WIDTH-1:0] retire;
  logic                    store_take, fault, stop, port_free;
  logic [TAG_BITS-1:0]     fault_tag;
  logic [DEC_BITS-1:0]     dec;

  assign port_free = !st_valid_q || st_ready_i;

  // Walk the window from the head; the first slot that cannot retire blocks every younger slot.
  always_comb begin
    retire     = '0;
    store_take = 1'b0;
    fault      = 1'b0;
    fault_tag  = '0;
    stop       = !reset_ni || (state_q != RUN) || retire_stall_i;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (!stop) begin
        if (rob_valid_i[i] && rob_ready_i[i] && !rob_exc_i[i] &&
            (!rob_store_i[i] || (!store_take && port_free && lsq_valid_i &&
                                 lsq_tag_i == rob_tag_i[i*TAG_BITS +: TAG_BITS]))) begin
          retire[i] = 1'b1;
          if (rob_store_i[i]) store_take = 1'b1;
        end else begin
          stop = 1'b1;
          if (rob_valid_i[i] && rob_ready_i[i] && rob_exc_i[i]) begin
            fault     = 1'b1;
            fault_tag = rob_tag_i[i*TAG_BITS +: TAG_BITS];
          end
        end
      end
    end
  end

  always_comb begin
    regwr_o = '0;
    rd_o    = '0;
    value_o = '0;
    dec     = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      dec = dec + DEC_BITS'(retire[i]);
      if (retire[i] && rob_regwr_i[i]) begin
        regwr_o[i]                   = 1'b1;
        rd_o[i*REG_BITS +: REG_BITS] = rob_rd_i[i*REG_BITS +: REG_BITS];
        if (rob_rd_i[i*REG_BITS +: REG_BITS] != '0)
          value_o[i*XLEN +: XLEN] = rob_value_i[i*XLEN +: XLEN];
      end
    end
  end

  assign victim_o        = regwr_o;
  assign rob_decrement_o = dec;
  assign lsq_decrement_o = store_take;

  always_comb begin
    case (lsq_size_i)
      2'd0:    mask_base = 16'h0001;
      2'd1:    mask_base = 16'h0003;
      2'd2:    mask_base = 16'h000F;
      default: mask_base = 16'h00FF;
    endcase
    mask_wide = mask_base << lsq_addr_i[2:0];
    st_mask_d = mask_wide[7:0];
  end

  // A new store may load on the same edge the previous one is accepted.
  assign st_valid_d = store_take ? 1'b1 : ((st_valid_q && st_ready_i) ? 1'b0 : st_valid_q);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      st_mask_q  <= '0;
    end else begin
      st_valid_q <= st_valid_d;
      if (store_take) begin
        st_addr_q <= {lsq_addr_i[XLEN-1:3], 3'b000};
        st_data_q <= lsq_data_i;
        st_mask_q <= st_mask_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= RUN;
      flush_q   <= 1'b0;
      exc_tag_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (fault) begin
            exc_tag_q <= fault_tag;
            if (st_valid_d) begin
              state_q <= DRAIN;
            end else begin
              state_q <= FLUSH;
              flush_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!st_valid_d) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign st_valid_o = st_valid_q;
  assign st_addr_o  = st_addr_q;
  assign st_data_o  = st_data_q;
  assign st_mask_o  = st_mask_q;
  assign flush_o    = flush_q;
  assign exc_tag_o  = exc_tag_q;

`ifdef RETIRE_PERF_EN
  logic [63:0] perf_retired_q;
  logic [31:0] perf_stall_q;
  logic [64:0] ret_sum;

  assign ret_sum = {1'b0, perf_retired_q} + 65'(dec);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= ret_sum[64] ? '1 : ret_sum[63:0];
      if (state_q == RUN && rob_valid_i[0] && !retire[0] && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_window.sv
`default_nettype none
// Self-checking bench for retire_window (W=2): retire window, store port scoreboard, fault/flush FSM.
module tb_retire_window;
  localparam int W  = 2;
  localparam int XL = 64;
  localparam int RB = 5;
  localparam int TB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, retire_stall;
  logic [W-1:0]    rob_valid, rob_ready, rob_exc, rob_store, rob_regwr;
  logic [W*TB-1:0] rob_tag;
  logic [W*RB-1:0] rob_rd;
  logic [W*XL-1:0] rob_value;
  logic            lsq_valid;
  logic [TB-1:0]   lsq_tag;
  logic [XL-1:0]   lsq_addr, lsq_data;
  logic [1:0]      lsq_size;
  logic [W-1:0]    regwr, victim;
  logic [W*RB-1:0] rd;
  logic [W*XL-1:0] value;
  logic [1:0]      rob_dec;
  logic            lsq_dec, st_valid, st_ready, flush;
  logic [XL-1:0]   st_addr, st_data;
  logic [7:0]      st_mask;
  logic [TB-1:0]   exc_tag;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } st_t;
  st_t exp_q[$];
  st_t acc;

  retire_window #(.RETIRE_WIDTH(W), .XLEN(XL), .REG_BITS(RB), .TAG_BITS(TB)) dut (
    .clk_i(clk), .reset_ni(reset_n), .retire_stall_i(retire_stall),
    .rob_valid_i(rob_valid), .rob_ready_i(rob_ready), .rob_exc_i(rob_exc),
    .rob_store_i(rob_store), .rob_regwr_i(rob_regwr), .rob_tag_i(rob_tag),
    .rob_rd_i(rob_rd), .rob_value_i(rob_value),
    .lsq_valid_i(lsq_valid), .lsq_tag_i(lsq_tag), .lsq_addr_i(lsq_addr),
    .lsq_data_i(lsq_data), .lsq_size_i(lsq_size),
    .regwr_o(regwr), .rd_o(rd), .value_o(value), .victim_o(victim),
    .rob_decrement_o(rob_dec), .lsq_decrement_o(lsq_dec),
    .st_valid_o(st_valid), .st_ready_i(st_ready), .st_addr_o(st_addr),
    .st_data_o(st_data), .st_mask_o(st_mask), .flush_o(flush), .exc_tag_o(exc_tag)
  );

  function automatic st_t model_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    st_t s;
    int  n, off;
    n      = 1 << sz;
    off    = int'(a[2:0]);
    s.addr = {a[63:3], 3'b000};
    s.data = d;
    s.mask = '0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + n) s.mask[b] = 1'b1;
    return s;
  endfunction

  task automatic clear_inputs();
    retire_stall = 1'b0;
    rob_valid = '0; rob_ready = '0; rob_exc = '0; rob_store = '0; rob_regwr = '0;
    rob_tag = '0; rob_rd = '0; rob_value = '0;
    lsq_valid = 1'b0; lsq_tag = '0; lsq_addr = '0; lsq_data = '0; lsq_size = '0;
  endtask

  task automatic set_slot(input int s, input logic v, input logic r, input logic e, input logic st,
                          input logic rw, input logic [TB-1:0] tag, input logic [RB-1:0] rdi,
                          input logic [XL-1:0] val);
    rob_valid[s] = v; rob_ready[s] = r; rob_exc[s] = e; rob_store[s] = st; rob_regwr[s] = rw;
    rob_tag[s*TB +: TB] = tag; rob_rd[s*RB +: RB] = rdi; rob_value[s*XL +: XL] = val;
  endtask

  task automatic set_lsq(input logic [TB-1:0] tag, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] sz);
    lsq_valid = 1'b1; lsq_tag = tag; lsq_addr = a; lsq_data = d; lsq_size = sz;
  endtask

  task automatic test_reset();
    clear_inputs(); st_ready = 1'b0; reset_n = 1'b0;
    set_slot(0, 1, 1, 0, 0, 1, 6'd1, 5'd3, 64'h11);
    #1;
    checks++; if ({regwr, rob_dec} !== 4'b0) begin errors++; $display("FAIL reset_comb: got regwr=%b dec=%0d, expected 0", regwr, rob_dec); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({st_valid, flush, exc_tag, st_mask, st_addr, st_data} !== '0) begin errors++; $display("FAIL reset_regs: got v=%b f=%b tag=%h m=%h a=%h, expected 0", st_valid, flush, exc_tag, st_mask, st_addr); end
    reset_n = 1'b1; clear_inputs();
  endtask

  task automatic test_alu_pair();
    @(negedge clk); clear_inputs();
    set_slot(0, 1, 1, 0, 0, 1, 6'd1, 5'd3, 64'hAAAA_0001);
    set_slot(1, 1, 1, 0, 0, 1, 6'd2, 5'd7, 64'hBBBB_0002);
    #1;
    checks++; if ({regwr, victim, rob_dec, lsq_dec} !== {2'b11, 2'b11, 2'd2, 1'b0}) begin errors++; $display("FAIL alu_pair_ctl: got regwr=%b victim=%b dec=%0d lsqdec=%b, expected 11 11 2 0", regwr, victim, rob_dec, lsq_dec); end
    checks++; if ({rd, value} !== {5'd7, 5'd3, 64'hBBBB_0002, 64'hAAAA_0001}) begin errors++; $display("FAIL alu_pair_data: got rd=%h value=%h", rd, value); end
    retire_stall = 1'b1; #1;
    checks++; if ({regwr, rob_dec} !== 4'b0) begin errors++; $display("FAIL stall: got regwr=%b dec=%0d, expected 0", regwr, rob_dec); end
    retire_stall = 1'b0;
  endtask

  task automatic test_rd_zero();
    @(negedge clk); clear_inputs();
    set_slot(0, 1, 1, 0, 0, 1, 6'd3, 5'd0, 64'd5);
    set_slot(1, 1, 0, 0, 0, 1, 6'd4, 5'd9, 64'd9);
    #1;
    checks++; if ({regwr, victim, rob_dec} !== {2'b01, 2'b01, 2'd1}) begin errors++; $display("FAIL rd_zero_ctl: got regwr=%b victim=%b dec=%0d, expected 01 01 1", regwr, victim, rob_dec); end
    checks++; if (value !== '0) begin errors++; $display("FAIL rd_zero_value: got %h, expected 0", value); end
  endtask

  task automatic test_empty();
    @(negedge clk); clear_inputs(); #1;
    checks++; if ({regwr, victim, rob_dec, lsq_dec, rd, value} !== '0) begin errors++; $display("FAIL empty: got regwr=%b dec=%0d lsqdec=%b", regwr, rob_dec, lsq_dec); end
  endtask

  task automatic test_store();
    @(negedge clk); clear_inputs(); st_ready = 1'b0;
    set_slot(0, 1, 1, 0, 1, 0, 6'd5, 5'd0, 64'd0);
    set_slot(1, 1, 1, 0, 1, 0, 6'd6, 5'd0, 64'd0);
    set_lsq(6'd5, 64'h1004, 64'hDEAD_BEEF, 2'd2);
    #1;
    checks++; if ({rob_dec, lsq_dec} !== {2'd1, 1'b1}) begin errors++; $display("FAIL store_retire: got dec=%0d lsqdec=%b, expected 1 1", rob_dec, lsq_dec); end
    exp_q.push_back(model_store(lsq_addr, lsq_data, lsq_size));
    @(posedge clk); #1;
    checks++; if ({st_valid, st_mask, st_addr} !== {1'b1, 8'hF0, 64'h1000}) begin errors++; $display("FAIL store_sw: got v=%b mask=%h addr=%h, expected 1 f0 1000", st_valid, st_mask, st_addr); end
    checks++; if ({st_addr, st_data, st_mask} !== exp_q[0]) begin errors++; $display("FAIL store_payload: got %h, expected %h", {st_addr, st_data, st_mask}, exp_q[0]); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clear_inputs(); st_ready = 1'b0;
      set_slot(0, 1, 1, 0, 1, 0, 6'd6, 5'd0, 64'd0);
      set_lsq(6'd6, 64'h2003, 64'hAB, 2'd0);
      #1;
      checks++; if ({rob_dec, lsq_dec} !== 3'b0) begin errors++; $display("FAIL b2b_blocked: got dec=%0d lsqdec=%b, expected 0", rob_dec, lsq_dec); end
      @(posedge clk); #1;
      checks++; if ({st_valid, st_addr, st_data, st_mask} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL b2b_stable: got v=%b %h, expected %h", st_valid, {st_addr, st_data, st_mask}, exp_q[0]); end
    end
    @(negedge clk); st_ready = 1'b1; #1;
    checks++; if ({rob_dec, lsq_dec} !== {2'd1, 1'b1}) begin errors++; $display("FAIL b2b_retire: got dec=%0d lsqdec=%b, expected 1 1", rob_dec, lsq_dec); end
    acc = exp_q.pop_front();
    checks++; if ({st_valid, st_addr, st_data, st_mask} !== {1'b1, acc}) begin errors++; $display("FAIL b2b_accept1: got %h, expected %h", {st_addr, st_data, st_mask}, acc); end
    exp_q.push_back(model_store(lsq_addr, lsq_data, lsq_size));
    @(posedge clk); #1;
    checks++; if ({st_valid, st_addr, st_data, st_mask} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL b2b_reload: got v=%b %h, expected %h", st_valid, {st_addr, st_data, st_mask}, exp_q[0]); end
    @(negedge clk); clear_inputs(); st_ready = 1'b1; #1;
    acc = exp_q.pop_front();
    checks++; if ({st_valid, st_addr, st_data, st_mask} !== {1'b1, acc}) begin errors++; $display("FAIL b2b_accept2: got %h, expected %h", {st_addr, st_data, st_mask}, acc); end
    @(posedge clk); #1;
    checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got st_valid=%b, expected 0", st_valid); end
  endtask

  task automatic load_blocked_store(input logic [TB-1:0] tag);
    @(negedge clk); clear_inputs(); st_ready = 1'b0;
    set_slot(0, 1, 1, 0, 1, 0, tag, 5'd0, 64'd0);
    set_lsq(tag, 64'h3000, 64'h1234, 2'd3);
    #1;
    exp_q.push_back(model_store(lsq_addr, lsq_data, lsq_size));
    @(posedge clk);
  endtask

  task automatic test_fault_drain();
    load_blocked_store(6'd10);
    @(negedge clk); clear_inputs();
    set_slot(0, 1, 1, 0, 0, 1, 6'd11, 5'd4, 64'h44);
    set_slot(1, 1, 1, 1, 0, 1, 6'd12, 5'd8, 64'h88);
    #1;
    checks++; if ({rob_dec, regwr} !== {2'd1, 2'b01}) begin errors++; $display("FAIL fault_partial: got dec=%0d regwr=%b, expected 1 01", rob_dec, regwr); end
    @(posedge clk); #1;
    checks++; if ({flush, st_valid} !== 2'b01) begin errors++; $display("FAIL drain_enter: got flush=%b st_valid=%b, expected 0 1", flush, st_valid); end
    @(negedge clk); clear_inputs();
    set_slot(0, 1, 1, 0, 0, 1, 6'd13, 5'd4, 64'h44);
    #1;
    checks++; if (rob_dec !== 2'd0) begin errors++; $display("FAIL drain_no_retire: got dec=%0d, expected 0", rob_dec); end
    @(posedge clk);
    @(negedge clk); st_ready = 1'b1; #1;
    acc = exp_q.pop_front();
    checks++; if ({rob_dec, st_valid, st_addr, st_data, st_mask} !== {2'd0, 1'b1, acc}) begin errors++; $display("FAIL drain_accept: got dec=%0d %h, expected 0 %h", rob_dec, {st_addr, st_data, st_mask}, acc); end
    @(posedge clk); #1;
    checks++; if ({flush, exc_tag, st_valid} !== {1'b1, 6'd12, 1'b0}) begin errors++; $display("FAIL flush_pulse: got flush=%b tag=%0d st_valid=%b, expected 1 12 0", flush, exc_tag, st_valid); end
    @(negedge clk); #1;
    checks++; if (rob_dec !== 2'd0) begin errors++; $display("FAIL flush_no_retire: got dec=%0d, expected 0", rob_dec); end
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: got flush=%b, expected 0", flush); end
    @(negedge clk); #1;
    checks++; if (rob_dec !== 2'd1) begin errors++; $display("FAIL back_to_run: got dec=%0d, expected 1", rob_dec); end
    st_ready = 1'b0;
  endtask

  task automatic test_fault_flush();
    @(negedge clk); clear_inputs(); st_ready = 1'b0;
    set_slot(0, 1, 1, 1, 0, 1, 6'd20, 5'd2, 64'h22);
    #1;
    checks++; if ({rob_dec, regwr} !== 4'b0) begin errors++; $display("FAIL head_fault: got dec=%0d regwr=%b, expected 0", rob_dec, regwr); end
    @(posedge clk); #1;
    checks++; if ({flush, exc_tag} !== {1'b1, 6'd20}) begin errors++; $display("FAIL direct_flush: got flush=%b tag=%0d, expected 1 20", flush, exc_tag); end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL direct_flush_end: got flush=%b, expected 0", flush); end
  endtask

  task automatic test_reset_mid_drain();
    load_blocked_store(6'd30);
    @(negedge clk); clear_inputs();
    set_slot(0, 1, 1, 1, 0, 0, 6'd31, 5'd0, 64'd0);
    @(posedge clk); #1;
    checks++; if ({st_valid, flush} !== 2'b10) begin errors++; $display("FAIL pre_reset_drain: got st_valid=%b flush=%b, expected 1 0", st_valid, flush); end
    @(negedge clk); clear_inputs(); #2;
    reset_n = 1'b0; #1;
    checks++; if ({st_valid, flush, st_mask} !== '0) begin errors++; $display("FAIL async_reset: got st_valid=%b flush=%b mask=%h, expected 0", st_valid, flush, st_mask); end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    set_slot(0, 1, 1, 0, 0, 1, 6'd32, 5'd6, 64'h66);
    #1;
    checks++; if ({rob_dec, regwr, st_valid} !== {2'd1, 2'b01, 1'b0}) begin errors++; $display("FAIL run_after_reset: got dec=%0d regwr=%b st_valid=%b, expected 1 01 0", rob_dec, regwr, st_valid); end
    @(posedge clk); #1;
    checks++; if ({flush, st_valid} !== 2'b00) begin errors++; $display("FAIL no_flush_after_reset: got flush=%b st_valid=%b, expected 0 0", flush, st_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_alu_pair();
    test_rd_zero();
    test_empty();
    test_store();
    test_back_to_back();
    test_fault_drain();
    test_fault_flush();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
